// File: rtl/comp_mac_ctrl.sv
// Frame controller that feeds a complex multiplier and accumulates LEN products into one dot product.
// Build option COMP_MAC_CONJ_EN: multiply each sample by the conjugate of its coefficient.
module comp_mac_ctrl #(
    parameter int DWIDTH = 8,
    parameter int LEN_W  = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              sw_rst,
    input  logic                              start,
    input  logic [LEN_W-1:0]                  cfg_len,
    output logic                              busy,
    input  logic                              smp_val,
    output logic                              smp_rdy,
    input  logic [2*DWIDTH-1:0]               smp_data,
    input  logic                              coef_val,
    output logic                              coef_rdy,
    input  logic [2*DWIDTH-1:0]               coef_data,
    output logic                              op_val,
    input  logic                              op_rdy,
    output logic [4*DWIDTH-1:0]               op_data,
    input  logic                              res_val,
    output logic                              res_rdy,
    input  logic [4*DWIDTH+3:0]               res_data,
    output logic                              acc_val,
    input  logic                              acc_rdy,
    output logic [2*(2*DWIDTH+2+LEN_W)-1:0]   acc_data
);

    localparam int PWIDTH = 2*DWIDTH + 2;
    localparam int AWIDTH = PWIDTH + LEN_W;
    localparam int CW     = LEN_W + 1;
    localparam logic [CW-1:0] LEN_MAX = {1'b1, {LEN_W{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           len_q, len_d;
    logic [CW-1:0]           iss_q, iss_d;
    logic [CW-1:0]           rcv_q, rcv_d;
    logic signed [AWIDTH-1:0] xa_q, xa_d, ya_q, ya_d;
    logic [2*AWIDTH-1:0]     acc_q, acc_d;

    logic                    op_hs, res_hs;
    logic [DWIDTH-1:0]       y2_raw, y2_eff;
    logic [PWIDTH-1:0]       xr, yr;
    logic signed [AWIDTH-1:0] xr_ext, yr_ext;

    assign y2_raw = coef_data[DWIDTH-1:0];

`ifdef COMP_MAC_CONJ_EN
    localparam logic [DWIDTH-1:0] D_MIN = {1'b1, {(DWIDTH-1){1'b0}}};
    localparam logic [DWIDTH-1:0] D_MAX = {1'b0, {(DWIDTH-1){1'b1}}};
    // The most negative value has no positive twin, so its negation clips.
    assign y2_eff = (y2_raw == D_MIN) ? D_MAX : (~y2_raw + 1'b1);
`else
    assign y2_eff = y2_raw;
`endif

    assign op_data = {smp_data, coef_data[2*DWIDTH-1:DWIDTH], y2_eff};

    assign xr     = res_data[2*PWIDTH-1:PWIDTH];
    assign yr     = res_data[PWIDTH-1:0];
    assign xr_ext = {{LEN_W{xr[PWIDTH-1]}}, xr};
    assign yr_ext = {{LEN_W{yr[PWIDTH-1]}}, yr};

    assign op_hs  = op_val & op_rdy;
    assign res_hs = res_val & res_rdy;

    // NOTE: every signal driven here gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        iss_d    = iss_q + {{LEN_W{1'b0}}, op_hs};
        rcv_d    = rcv_q + {{LEN_W{1'b0}}, res_hs};
        xa_d     = res_hs ? xa_q + xr_ext : xa_q;
        ya_d     = res_hs ? ya_q + yr_ext : ya_q;
        acc_d    = acc_q;
        busy     = (state_q != S_IDLE);
        op_val   = 1'b0;
        res_rdy  = 1'b0;
        acc_val  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = (cfg_len == '0) ? LEN_MAX : {1'b0, cfg_len};
                    iss_d   = '0;
                    rcv_d   = '0;
                    xa_d    = '0;
                    ya_d    = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                op_val  = smp_val & coef_val & (iss_q < len_q);
                res_rdy = 1'b1;
                if (iss_d == len_q) begin
                    if (rcv_d == len_q) begin
                        acc_d   = {xa_d, ya_d};
                        state_d = S_OUT;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                res_rdy = 1'b1;
                // Capture includes the product accepted this very cycle.
                if (rcv_d == len_q) begin
                    acc_d   = {xa_d, ya_d};
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                acc_val = 1'b1;
                if (acc_rdy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign smp_rdy  = op_hs;
    assign coef_rdy = op_hs;
    assign acc_data = acc_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            iss_q   <= '0;
            rcv_q   <= '0;
            xa_q    <= '0;
            ya_q    <= '0;
            acc_q   <= '0;
        end else if (sw_rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            iss_q   <= '0;
            rcv_q   <= '0;
            xa_q    <= '0;
            ya_q    <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            iss_q   <= iss_d;
            rcv_q   <= rcv_d;
            xa_q    <= xa_d;
            ya_q    <= ya_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: tb/tb_comp_mac_ctrl.sv
// Directed bench for comp_mac_ctrl with a small in-order multiplier model behind the op/res ports.
module tb_comp_mac_ctrl;

    localparam int DWIDTH = 8;
    localparam int LEN_W  = 4;
    localparam int AWIDTH = 2*DWIDTH + 2 + LEN_W;

    logic clk = 1'b0;
    logic rst_n, sw_rst, start;
    logic [LEN_W-1:0] cfg_len;
    logic busy;
    logic smp_val, smp_rdy, coef_val, coef_rdy;
    logic [2*DWIDTH-1:0] smp_data, coef_data;
    logic op_val, op_rdy;
    logic [4*DWIDTH-1:0] op_data;
    logic res_val, res_rdy;
    logic [4*DWIDTH+3:0] res_data;
    logic acc_val, acc_rdy;
    logic [2*AWIDTH-1:0] acc_data;

    logic res_en;
    logic [31:0] mem [0:31];
    logic [5:0]  wr_ptr, rd_ptr;
    int          hs_cnt = 0;
    int          viol   = 0;
    logic [31:0] last_op = '0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    comp_mac_ctrl #(.DWIDTH(DWIDTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .sw_rst(sw_rst), .start(start), .cfg_len(cfg_len),
        .busy(busy), .smp_val(smp_val), .smp_rdy(smp_rdy), .smp_data(smp_data),
        .coef_val(coef_val), .coef_rdy(coef_rdy), .coef_data(coef_data),
        .op_val(op_val), .op_rdy(op_rdy), .op_data(op_data),
        .res_val(res_val), .res_rdy(res_rdy), .res_data(res_data),
        .acc_val(acc_val), .acc_rdy(acc_rdy), .acc_data(acc_data)
    );

    function automatic logic [35:0] mult(input logic [31:0] op);
        int x1, y1, x2, y2, xr, yr;
        x1 = $signed(op[31:24]);
        y1 = $signed(op[23:16]);
        x2 = $signed(op[15:8]);
        y2 = $signed(op[7:0]);
        xr = x1*x2 - y1*y2;
        yr = x1*y2 + y1*x2;
        return {xr[17:0], yr[17:0]};
    endfunction

    function automatic logic [2*AWIDTH-1:0] pack_acc(input int xa, input int ya);
        return {xa[AWIDTH-1:0], ya[AWIDTH-1:0]};
    endfunction

    // In-order multiplier model; it shares the controller's resets.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (sw_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (op_val && op_rdy) begin
                mem[wr_ptr[4:0]] <= op_data;
                wr_ptr <= wr_ptr + 6'd1;
            end
            if (res_val && res_rdy) rd_ptr <= rd_ptr + 6'd1;
        end
    end

    assign res_val  = res_en && (wr_ptr != rd_ptr);
    assign res_data = mult(mem[rd_ptr[4:0]]);

    always @(posedge clk) begin
        if (op_val && op_rdy) begin
            hs_cnt  <= hs_cnt + 1;
            last_op <= op_data;
        end
        if (rst_n && ((smp_rdy !== (op_val & op_rdy)) || (coef_rdy !== smp_rdy)))
            viol <= viol + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [LEN_W-1:0] len);
        @(negedge clk);
        cfg_len = len;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic run_to_out(input bit toggle, input bit gap, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (acc_val) begin
                ok = 1'b1;
                break;
            end
            op_rdy = toggle ? c[0] : 1'b1;
            res_en = gap ? (c % 3 == 0) : 1'b1;
        end
        op_rdy = 1'b1;
        res_en = 1'b1;
    endtask

    task automatic release_out();
        @(negedge clk);
        acc_rdy = 1'b1;
        @(negedge clk);
        acc_rdy = 1'b0;
    endtask

    initial begin
        int base;
        bit ok;
        logic [2*AWIDTH-1:0] saved;

        rst_n = 1'b0; sw_rst = 1'b0; start = 1'b0; cfg_len = '0;
        smp_val = 1'b0; coef_val = 1'b0; smp_data = '0; coef_data = '0;
        op_rdy = 1'b1; res_en = 1'b1; acc_rdy = 1'b0;

        #12;
        chk("reset_busy",     busy,     0);
        chk("reset_op_val",   op_val,   0);
        chk("reset_rdys",     {smp_rdy, coef_rdy, res_rdy}, 0);
        chk("reset_acc_val",  acc_val,  0);
        chk("reset_acc_data", acc_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single pair, multiplier always ready
        smp_val = 1'b1; coef_val = 1'b1;
        smp_data = 16'h0102; coef_data = 16'h0304;
        base = hs_cnt;
        do_start(4'd1);
        chk("t1_busy", busy, 1);
        run_to_out(1'b0, 1'b0, ok);
        chk("t1_reach_out", ok, 1);
        chk("t1_op_data", last_op, 32'h01020304);
        chk("t1_hs", hs_cnt - base, 1);
        chk("t1_acc", acc_data, pack_acc(-5, 10));
        repeat (3) @(negedge clk);
        chk("t1_acc_held", {acc_val, acc_data}, {1'b1, pack_acc(-5, 10)});
        release_out();
        chk("t1_idle", {busy, acc_val}, 0);
        chk("t1_idle_no_op", {op_val, res_rdy, smp_rdy}, 0);

        // 2: three pairs, op_rdy toggling and gapped results
        base = hs_cnt;
        do_start(4'd3);
        run_to_out(1'b1, 1'b1, ok);
        chk("t2_reach_out", ok, 1);
        chk("t2_hs", hs_cnt - base, 3);
        chk("t2_acc", acc_data, pack_acc(-15, 30));
        release_out();

        // 3: len 0 means 16, extreme operands
        smp_data = 16'h8080; coef_data = 16'h8080;
        base = hs_cnt;
        do_start(4'd0);
        run_to_out(1'b0, 1'b0, ok);
        chk("t3_reach_out", ok, 1);
        chk("t3_hs", hs_cnt - base, 16);
        chk("t3_acc", acc_data, pack_acc(0, 524288));
        release_out();

        // 4: software reset mid-frame, then a fresh frame
        smp_data = 16'h0102; coef_data = 16'h0304;
        res_en = 1'b0;
        base = hs_cnt;
        do_start(4'd5);
        for (int c = 0; c < 50; c++) begin
            if (hs_cnt - base >= 2) break;
            @(negedge clk);
        end
        chk("t4_two_issued", hs_cnt - base, 2);
        sw_rst = 1'b1;
        @(negedge clk);
        chk("t4_busy", busy, 0);
        chk("t4_outputs", {op_val, smp_rdy, coef_rdy, res_rdy, acc_val}, 0);
        chk("t4_acc_data", acc_data, 0);
        sw_rst = 1'b0;
        res_en = 1'b1;
        do_start(4'd1);
        run_to_out(1'b0, 1'b0, ok);
        chk("t4_reach_out", ok, 1);
        chk("t4_fresh_acc", acc_data, pack_acc(-5, 10));

        // 5: hold in OUT and try to start again
        saved = acc_data;
        repeat (4) @(negedge clk);
        cfg_len = 4'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5_acc_stable", acc_data, saved);
        chk("t5_val_busy", {acc_val, busy}, 2'b11);
        release_out();
        chk("t5_idle", {busy, acc_val}, 0);
        @(negedge clk);
        chk("t5_start_ignored", busy, 0);

        // 6: coefficient negation option
`ifdef COMP_MAC_CONJ_EN
        do_start(4'd1);
        run_to_out(1'b0, 1'b0, ok);
        chk("t6_op_data", last_op, 32'h010203FC);
        chk("t6_acc", acc_data, pack_acc(11, 2));
        release_out();
        coef_data = 16'h0080;
        do_start(4'd1);
        run_to_out(1'b0, 1'b0, ok);
        chk("t6_sat_y2", last_op[7:0], 8'h7F);
        chk("t6_sat_acc", acc_data, pack_acc(-254, 127));
        release_out();
`else
        coef_data = 16'h0080;
        do_start(4'd1);
        run_to_out(1'b0, 1'b0, ok);
        chk("t6_y2_pass", last_op[7:0], 8'h80);
        chk("t6_acc", acc_data, pack_acc(256, -128));
        release_out();
`endif

        chk("rdy_pulse_rule", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
